// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchroniser, polarity fix, 4-state debounce FSM with press/release pulses and run toggle.
// Optional long-press pulse is built only when KEY_DEBOUNCE_LONGPRESS_EN is defined.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter bit INV_BTN         = 1'b0,
    parameter int LONG_CYCLES     = 27000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_i,
    output logic       key_level,
    output logic       key_press,
    output logic       key_release,
    output logic       run_en,
    output logic       long_press,
    output logic [1:0] state_dbg
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        REL   = 2'd0,
        W_PR  = 2'd1,
        PR    = 2'd2,
        W_REL = 2'd3
    } state_t;

    state_t        state;
    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    assign state_dbg = state;

    // The counter is cleared on every state entry, so it never needs to wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            cnt         <= '0;
            state       <= REL;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            run_en      <= 1'b0;
        end else begin
            s1          <= key_i ^ INV_BTN;
            s2          <= s1;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            case (state)
                REL: begin
                    if (s2) begin
                        state <= W_PR;
                        cnt   <= '0;
                    end
                end
                W_PR: begin
                    if (!s2) begin
                        state <= REL;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= PR;
                        cnt       <= '0;
                        key_level <= 1'b1;
                        key_press <= 1'b1;
                        run_en    <= ~run_en;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PR: begin
                    if (!s2) begin
                        state <= W_REL;
                        cnt   <= '0;
                    end
                end
                W_REL: begin
                    if (s2) begin
                        state <= PR;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state       <= REL;
                        cnt         <= '0;
                        key_level   <= 1'b0;
                        key_release <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= REL;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef KEY_DEBOUNCE_LONGPRESS_EN
    localparam int LW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

    logic [LW-1:0] lcnt;
    logic          long_done;
    logic          enter_pr;

    // Entering PR either from an accepted press or from an aborted release restarts the hold count.
    assign enter_pr = (state == W_PR && s2 && cnt == CNT_LAST) || (state == W_REL && s2);

    always_ff @(posedge clk) begin
        if (rst) begin
            lcnt       <= '0;
            long_done  <= 1'b0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (enter_pr) begin
                lcnt      <= '0;
                long_done <= 1'b0;
            end else if (state == PR && !long_done) begin
                if (lcnt == LONG_LAST) begin
                    long_press <= 1'b1;
                    long_done  <= 1'b1;
                end else begin
                    lcnt <= lcnt + LW'(1);
                end
            end
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Conditions the raw board push-button before it gates the LED counter in the PLL-clocked blinky designs.
- Synchronises `key_i` into the PLL output clock domain, removes polarity using `INV_BTN`, and debounces it with a 4-state FSM.
- Outputs a clean level, one-cycle press/release pulses and a press-toggled run enable.
- The downstream counter uses `key_level` or `run_en` as its count enable.

Parameters:
- `DEBOUNCE_CYCLES`, 270000, number of consecutive stable cycles required to accept a level change; legal range ≥1.
- `INV_BTN`, 0, 1 = button is active-low on the pin; raw input is XORed with this value before synchronisation.
- `LONG_CYCLES`, 27000000, held-cycles threshold for `long_press`; used only with the optional feature; legal range ≥1.

Ports:
- `clk`  in  1  PLL output clock (`CLKOUT` domain); the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `key_i`  in  1  raw asynchronous button pin.
- `key_level`  out  1  debounced level; 1 = pressed.
- `key_press`  out  1  one-cycle pulse on an accepted press.
- `key_release`  out  1  one-cycle pulse on an accepted release.
- `run_en`  out  1  toggles on every accepted press.
- `long_press`  out  1  one-cycle pulse when a press has been held for `LONG_CYCLES`; tied 0 without the feature.

Behaviour:
- **Clock and reset.** One clock, `clk`. Reset is synchronous and active-high on `rst`.
- **Reset values.**
  - `key_level`, `key_press`, `key_release`, `run_en` and `long_press` are 0.
  - Synchroniser stages are 0.
  - The debounce counter is 0.
  - FSM state is `REL`.
- **Synchroniser.** `s1 <= key_i ^ INV_BTN`, then `s2 <= s1`. The FSM sees only `s2`.
- **Counter width.** Debounce counter width is `max(1, $clog2(DEBOUNCE_CYCLES))`. It never wraps: it is cleared on every state entry.
- **FSM states:** `REL` (stable released), `W_PR` (candidate press), `PR` (stable pressed), `W_REL` (candidate release).
  - `REL`: if `s2`=1, go to `W_PR` and set cnt=0.
  - `W_PR`:
    - if `s2`=0, go to `REL` with cnt=0 and no pulse (glitch rejected);
    - else if cnt==`DEBOUNCE_CYCLES`-1, go to `PR`;
    - else cnt++.
  - `PR`: if `s2`=0, go to `W_REL` and set cnt=0.
  - `W_REL`: mirror of `W_PR`. If `s2`=1, go back to `PR`; on reaching cnt==`DEBOUNCE_CYCLES`-1, go to `REL`.
- **Outputs on an accepted press** (`W_PR`→`PR` edge): `key_level` is set to 1, `key_press` is 1 for exactly one cycle, and `run_en` toggles, all on the same edge.
- **Outputs on an accepted release** (`W_REL`→`REL` edge): `key_level` is set to 0 and `key_release` is 1 for exactly one cycle.
- **Latency.** With `key_i` held at the pressed level, edge 1 is the first edge that samples it. `key_level` and `key_press` are registered high at edge `DEBOUNCE_CYCLES`+3. Release latency is identical.
- **Pulse exclusivity.** `key_press` and `key_release` are never asserted in the same cycle or in back-to-back cycles.
- **Reset mid-operation.** All state and outputs return to reset values on the next edge; a press in progress is discarded. If the button is still held after reset deasserts, it is re-detected as a fresh press, with full latency and a `run_en` toggle.
- **Reset has priority** over all FSM activity in the same cycle.

Optional Feature:
- **Macro:** `KEY_DEBOUNCE_LONGPRESS_EN`.
- **Defined:**
  - A second counter of width `max(1, $clog2(LONG_CYCLES))` clears on entry to `PR` and increments each cycle in `PR`.
  - When it equals `LONG_CYCLES`-1, `long_press` pulses for 1 cycle and the counter saturates, giving exactly one pulse per press.
  - The counter keeps its value while in `W_REL` and is cleared when the FSM returns to `PR` from `W_REL`.
  - A `W_REL` glitch therefore restarts the long-press count.
- **Undefined:** no second counter is built, and `long_press` is constant 0.

Test Plan:
1. `DEBOUNCE_CYCLES`=4, `INV_BTN`=0: raise `key_i` and hold it -> `key_level` rises at edge 7, `key_press` is high for 1 cycle at edge 7, `run_en` goes 0→1.
2. `DEBOUNCE_CYCLES`=4: `key_i` high for 3 cycles then low -> no `key_press`; `key_level`, `key_press` and `run_en` stay 0 and the FSM returns to `REL`.
3. `DEBOUNCE_CYCLES`=4: two complete press/release cycles -> 2 `key_press` and 2 `key_release` pulses, `run_en` reads 1 then 0, `key_level` falls at edge 7 after each release.
4. `INV_BTN`=1: `key_i` idles at 1 and drives 0 to press -> behaviour identical to scenario 1.
5. `rst` asserted for 1 cycle while in `W_PR` with cnt=2 and the key still held -> outputs are 0 after the reset edge; `key_press` occurs 7 edges after reset deasserts and `run_en`=1.
6. Macro defined, `LONG_CYCLES`=10, `DEBOUNCE_CYCLES`=4: hold 30 cycles -> exactly one `long_press` pulse, 10 cycles after the `key_press` edge; with the macro undefined, `long_press` is never 1.
